// File: rtl/mux_feed_serializer_if.sv
// Handshake bundle between a word producer, the serializer and the downstream bit consumer.
// The slave modport is the serializer's view; master is the producer/consumer side.
interface mux_feed_serializer_if #(
  parameter int WIDTH = 8
);
  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;
  logic             down_valid;
  logic             down_ready;
  logic             down_data;
  logic             down_last;
  logic             busy;

  modport slave (
    input  up_valid, up_data, down_ready,
    output up_ready, down_valid, down_data, down_last, busy
  );

  modport master (
    output up_valid, up_data, down_ready,
    input  up_ready, down_valid, down_data, down_last, busy
  );
endinterface

// File: rtl/mux_feed_serializer.sv
// Parallel-to-serial converter feeding the 1-bit data input of a downstream mux/gate stage.
// Words arrive over valid/ready and leave one bit per transfer, with a last-bit marker.
module mux_feed_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_feed_serializer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_next;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic             w_shift_st;
  logic             w_last;
  logic             w_up_ready;
  logic             w_up_xfer;
  logic             w_down_xfer;

  assign w_shift_st  = (r_state == S_SHIFT);
  assign w_last      = w_shift_st & (r_cnt == LAST_CNT);
  // The only combinational input-to-output path: down_ready lets a new word in on the last bit.
  assign w_up_ready  = rst_n & ((r_state == S_IDLE) | (w_last & bus.down_ready));
  assign w_up_xfer   = bus.up_valid & w_up_ready;
  assign w_down_xfer = w_shift_st & bus.down_ready;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_shreg <= w_shreg_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shreg_next = r_shreg;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_up_xfer) begin
          w_shreg_next = bus.up_data;
          w_cnt_next   = '0;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_down_xfer) begin
          if (!w_last) begin
            w_shreg_next = w_shifted;
            w_cnt_next   = r_cnt + CW'(1);
          end else if (w_up_xfer) begin
            // Reload on the final bit so consecutive words stream without a bubble.
            w_shreg_next = bus.up_data;
            w_cnt_next   = '0;
          end else begin
            w_shreg_next = '0;
            w_cnt_next   = '0;
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_shreg_next = '0;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign bus.up_ready   = w_up_ready;
  assign bus.down_valid = w_shift_st;
  assign bus.busy       = w_shift_st;
  assign bus.down_data  = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
  assign bus.down_last  = w_last;

endmodule

// File: tb/tb_mux_feed_serializer.sv
// Self-checking bench: directed scenarios on an 8-bit MSB-first and a 4-bit LSB-first instance,
// plus a randomized run checked against a bit-queue model of the serial stream.
module tb_mux_feed_serializer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mux_feed_serializer_if #(.WIDTH(8)) if8 ();
  mux_feed_serializer_if #(.WIDTH(4)) if4 ();

  mux_feed_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  mux_feed_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #1;
    n_checks++; if ({if8.down_valid, if8.down_data, if8.down_last, if8.busy, if8.up_ready} !== 5'b0) begin n_fail++; $display("FAIL reset_outs8 got %b want 00000", {if8.down_valid, if8.down_data, if8.down_last, if8.busy, if8.up_ready}); end
    n_checks++; if ({if4.down_valid, if4.down_last, if4.up_ready} !== 3'b0) begin n_fail++; $display("FAIL reset_outs4 got %b want 000", {if4.down_valid, if4.down_last, if4.up_ready}); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++; if (if8.up_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", if8.up_ready); end
    n_checks++; if (if8.down_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid got %b want 0", if8.down_valid); end
  endtask

  task automatic test_single(input logic [7:0] w);
    @(negedge clk); if8.up_valid = 1'b1; if8.up_data = w; if8.down_ready = 1'b1; #1;
    n_checks++; if (if8.up_ready !== 1'b1) begin n_fail++; $display("FAIL single_offer_ready got %b want 1", if8.up_ready); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); if8.up_valid = 1'b0; if8.up_data = 8'($urandom); #1;
      n_checks++; if (if8.down_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid bit%0d got %b want 1", i, if8.down_valid); end
      n_checks++; if (if8.down_data !== w[7-i]) begin n_fail++; $display("FAIL single_data word %h bit%0d got %b want %b", w, i, if8.down_data, w[7-i]); end
      n_checks++; if (if8.down_last !== (i == 7)) begin n_fail++; $display("FAIL single_last bit%0d got %b want %b", i, if8.down_last, (i == 7)); end
    end
    @(negedge clk); #1;
    n_checks++; if ({if8.down_valid, if8.busy, if8.up_ready} !== 3'b001) begin n_fail++; $display("FAIL single_idle got %b want 001", {if8.down_valid, if8.busy, if8.up_ready}); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    stream = 16'hA53C;
    @(negedge clk); if8.up_valid = 1'b1; if8.up_data = 8'hA5; if8.down_ready = 1'b1; #1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); if8.up_valid = (i < 8); if8.up_data = (i < 8) ? 8'h3C : 8'($urandom); #1;
      n_checks++; if (if8.down_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid bit%0d got %b want 1", i, if8.down_valid); end
      n_checks++; if (if8.down_data !== stream[15-i]) begin n_fail++; $display("FAIL b2b_data bit%0d got %b want %b", i, if8.down_data, stream[15-i]); end
      n_checks++; if (if8.up_ready !== (i == 7 || i == 15)) begin n_fail++; $display("FAIL b2b_up_ready bit%0d got %b want %b", i, if8.up_ready, (i == 7 || i == 15)); end
      n_checks++; if (if8.down_last !== (i == 7 || i == 15)) begin n_fail++; $display("FAIL b2b_last bit%0d got %b want %b", i, if8.down_last, (i == 7 || i == 15)); end
    end
    @(negedge clk); if8.up_valid = 1'b0; #1;
    n_checks++; if (if8.down_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b want 0", if8.down_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0]  w;
    logic [11:0] pat;
    int          k;
    w   = 8'hF0;
    pat = 12'b1011_1100_0111;
    k   = 0;
    @(negedge clk); if8.up_valid = 1'b1; if8.up_data = w; if8.down_ready = 1'b1; #1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); if8.up_valid = 1'b0; if8.down_ready = pat[c]; #1;
      n_checks++; if (if8.down_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc%0d got %b want 1", c, if8.down_valid); end
      n_checks++; if (if8.down_data !== w[7-k]) begin n_fail++; $display("FAIL bp_data cyc%0d bit%0d got %b want %b", c, k, if8.down_data, w[7-k]); end
      n_checks++; if (if8.down_last !== (k == 7)) begin n_fail++; $display("FAIL bp_last cyc%0d got %b want %b", c, if8.down_last, (k == 7)); end
      n_checks++; if (if8.up_ready !== (k == 7 && pat[c])) begin n_fail++; $display("FAIL bp_up_ready cyc%0d got %b want %b", c, if8.up_ready, (k == 7 && pat[c])); end
      if (pat[c]) k++;
    end
    @(negedge clk); if8.down_ready = 1'b1; #1;
    n_checks++; if (if8.down_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle got %b want 0", if8.down_valid); end
  endtask

  task automatic test_midword_offer();
    logic [15:0] stream;
    logic        rdy;
    logic        taken;
    int          k;
    stream = 16'h9655;
    taken  = 1'b0;
    k      = 0;
    @(negedge clk); if8.up_valid = 1'b1; if8.up_data = 8'h96; if8.down_ready = 1'b1; #1;
    for (int c = 0; c < 17; c++) begin
      rdy = (c != 7);
      @(negedge clk); if8.up_valid = !taken; if8.up_data = taken ? 8'($urandom) : 8'h55; if8.down_ready = rdy; #1;
      n_checks++; if (if8.down_data !== stream[15-k]) begin n_fail++; $display("FAIL mid_data cyc%0d bit%0d got %b want %b", c, k, if8.down_data, stream[15-k]); end
      n_checks++; if (if8.up_ready !== ((k == 7 || k == 15) && rdy)) begin n_fail++; $display("FAIL mid_up_ready cyc%0d bit%0d got %b want %b", c, k, if8.up_ready, ((k == 7 || k == 15) && rdy)); end
      if (if8.up_valid && if8.up_ready) taken = 1'b1;
      if (rdy) k++;
    end
    n_checks++; if (taken !== 1'b1) begin n_fail++; $display("FAIL mid_taken got %b want 1", taken); end
    @(negedge clk); if8.up_valid = 1'b0; #1;
    n_checks++; if (if8.down_valid !== 1'b0) begin n_fail++; $display("FAIL mid_idle got %b want 0", if8.down_valid); end
  endtask

  task automatic test_lsb_first();
    logic [3:0] w;
    for (int n = 0; n < 5; n++) begin
      w = (n == 0) ? 4'b0001 : 4'($urandom);
      @(negedge clk); if4.up_valid = 1'b1; if4.up_data = w; if4.down_ready = 1'b1; #1;
      n_checks++; if (if4.up_ready !== 1'b1) begin n_fail++; $display("FAIL lsb_offer_ready word%0d got %b want 1", n, if4.up_ready); end
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); if4.up_valid = 1'b0; if4.up_data = 4'($urandom); #1;
        n_checks++; if (if4.down_data !== w[i]) begin n_fail++; $display("FAIL lsb_data word %h bit%0d got %b want %b", w, i, if4.down_data, w[i]); end
        n_checks++; if (if4.down_last !== (i == 3)) begin n_fail++; $display("FAIL lsb_last bit%0d got %b want %b", i, if4.down_last, (i == 3)); end
      end
      @(negedge clk); #1;
      n_checks++; if ({if4.down_valid, if4.up_ready} !== 2'b01) begin n_fail++; $display("FAIL lsb_idle got %b want 01", {if4.down_valid, if4.up_ready}); end
    end
    if4.down_ready = 1'b0;
  endtask

  task automatic test_reset_midword();
    logic [7:0] w;
    w = 8'hC3;
    @(negedge clk); if8.up_valid = 1'b1; if8.up_data = w; if8.down_ready = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); if8.up_valid = 1'b0; #1;
      n_checks++; if (if8.down_data !== w[7-i]) begin n_fail++; $display("FAIL rstmid_data bit%0d got %b want %b", i, if8.down_data, w[7-i]); end
    end
    #2; rst_n = 1'b0; #1;
    n_checks++; if ({if8.down_valid, if8.down_data, if8.down_last, if8.busy, if8.up_ready} !== 5'b0) begin n_fail++; $display("FAIL rstmid_async got %b want 00000", {if8.down_valid, if8.down_data, if8.down_last, if8.busy, if8.up_ready}); end
    @(posedge clk); #1;
    n_checks++; if ({if8.down_valid, if8.up_ready} !== 2'b0) begin n_fail++; $display("FAIL rstmid_held got %b want 00", {if8.down_valid, if8.up_ready}); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++; if (if8.up_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_release got %b want 1", if8.up_ready); end
    test_single(8'h81);
  endtask

  task automatic test_random();
    logic [1:0] q[$];
    logic [7:0] w;
    logic       pend;
    logic       exp_rdy;
    pend = 1'b0;
    w    = '0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (!pend && c < 600 && ($urandom_range(2) != 0)) begin
        pend = 1'b1;
        w    = 8'($urandom);
      end
      if8.up_valid   = pend;
      if8.up_data    = pend ? w : 8'($urandom);
      if8.down_ready = (c >= 600) ? 1'b1 : ($urandom_range(3) != 0);
      #1;
      exp_rdy = (q.size() == 0) || (q.size() == 1 && if8.down_ready);
      n_checks++; if (if8.down_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc%0d got %b want %b", c, if8.down_valid, (q.size() != 0)); end
      n_checks++; if (if8.up_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_up_ready cyc%0d got %b want %b", c, if8.up_ready, exp_rdy); end
      if (q.size() != 0) begin
        n_checks++; if ({if8.down_data, if8.down_last} !== q[0]) begin n_fail++; $display("FAIL rnd_bit cyc%0d got data/last %b want %b", c, {if8.down_data, if8.down_last}, q[0]); end
      end
      if (if8.down_valid && if8.down_ready && q.size() != 0) void'(q.pop_front());
      if (if8.up_valid && if8.up_ready) begin
        for (int i = 7; i >= 0; i--) q.push_back({w[i], (i == 0)});
        pend = 1'b0;
      end
    end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain got %0d bits left want 0", q.size()); end
    if8.up_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    if8.up_valid = 1'b0; if8.up_data = '0; if8.down_ready = 1'b0;
    if4.up_valid = 1'b0; if4.up_data = '0; if4.down_ready = 1'b0;
    test_reset();
    test_single(8'hA5);
    test_back_to_back();
    test_backpressure();
    test_lsb_first();
    test_midword_offer();
    test_reset_midword();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
